// File: rtl/mix_columns_iter.sv
// ---------------------------------------------------------------------------
// mix_columns_iter
//
// Iterative AES MixColumns / InvMixColumns stage for the round datapath
// (between ShiftRows and AddRoundKey). A 128-bit state is captured on an
// input handshake. COLS_PER_CYCLE columns are then transformed in place per
// clock, and the result is offered on an output handshake. Each state takes
// N = 4/COLS_PER_CYCLE transform cycles. States never overlap.
//
// Parameters:
//   COLS_PER_CYCLE : columns transformed per clock (1, 2 or 4)
//   ENABLE_INV     : 1 = inv input selects InvMixColumns
//                    0 = forward only; the inverse logic is not built
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/inv are valid
//   in_ready   block can accept a state (only in IDLE and out of reset)
//   in_data    state; column 0 = [127:96] .. column 3 = [31:0],
//              byte 0 of a column is its MSB byte
//   inv        1 = InvMixColumns (ignored when ENABLE_INV = 0)
//   out_valid  out_data holds a completed result
//   out_ready  downstream accepts the result
//   out_data   transformed state, same byte order as in_data
//   busy       high while a state is being transformed or awaiting hand-off
// ---------------------------------------------------------------------------
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 4,
    parameter int ENABLE_INV     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // Guard against a divide-by-zero before the legality check can report.
    localparam int         N_CYC    = (COLS_PER_CYCLE > 0) ? (4 / COLS_PER_CYCLE) : 1;
    localparam logic [1:0] LAST_CNT = 2'(N_CYC - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         mode_q, mode_d;
    logic [127:0] work_mixed;

    // -----------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial x^8 + x^4 + x^3 + x + 1 (0x11B)
    // -----------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward column: r0 = 2a0 ^ 3a1 ^ a2 ^ a3, rotated for r1..r3.
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        // 3a = xtime(a) ^ a
        return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                a0 ^ x1 ^ x2 ^ a2 ^ a3,
                a0 ^ a1 ^ x2 ^ x3 ^ a3,
                x0 ^ a0 ^ a1 ^ a2 ^ x3};
    endfunction

    // Returns {0E*b, 0B*b, 0D*b, 09*b} built from one xtime chain.
    function automatic logic [31:0] inv_mults(input logic [7:0] b);
        logic [7:0] m2, m4, m8;
        m2 = xtime(b);
        m4 = xtime(m2);
        m8 = xtime(m4);
        return {m8 ^ m4 ^ m2, m8 ^ m2 ^ b, m8 ^ m4 ^ b, m8 ^ b};
    endfunction

    // Inverse column: r0 = 0Ea0 ^ 0Ba1 ^ 0Da2 ^ 09a3, rotated for r1..r3.
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] e0, b0, d0, n0;
        logic [7:0] e1, b1, d1, n1;
        logic [7:0] e2, b2, d2, n2;
        logic [7:0] e3, b3, d3, n3;
        {e0, b0, d0, n0} = inv_mults(col[31:24]);
        {e1, b1, d1, n1} = inv_mults(col[23:16]);
        {e2, b2, d2, n2} = inv_mults(col[15:8]);
        {e3, b3, d3, n3} = inv_mults(col[7:0]);
        return {e0 ^ b1 ^ d2 ^ n3,
                n0 ^ e1 ^ b2 ^ d3,
                d0 ^ n1 ^ e2 ^ b3,
                b0 ^ d1 ^ n2 ^ e3};
    endfunction

    // With ENABLE_INV = 0 the inverse branch is constant-false and drops out.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic use_inv);
        if (ENABLE_INV != 0 && use_inv) begin
            return mix_inv(col);
        end
        return mix_fwd(col);
    endfunction

    // LSB position of the column handled by lane u in the current cycle.
    // Column index is cnt*C + u (always 0..3); its LSB is (3 - idx) * 32.
    function automatic logic [6:0] col_lsb(input logic [1:0] cnt, input int u);
        logic [1:0] idx;
        idx = 2'(int'(cnt) * COLS_PER_CYCLE + u);
        return {~idx, 5'd0};
    endfunction

    // -----------------------------------------------------------------------
    // Column lanes: only COLS_PER_CYCLE mixers exist; each is muxed onto the
    // column selected by the counter and written back in place.
    // -----------------------------------------------------------------------
    always_comb begin
        work_mixed = work_q;
        for (int u = 0; u < COLS_PER_CYCLE; u++) begin
            work_mixed[col_lsb(cnt_q, u) +: 32] = mix_col(work_q[col_lsb(cnt_q, u) +: 32], mode_q);
        end
    end

    // -----------------------------------------------------------------------
    // Control: next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Held low while reset is asserted even though state is IDLE.
                in_ready = rst_n;
                if (in_valid) begin
                    work_d  = in_data;
                    mode_d  = (ENABLE_INV != 0) ? inv : 1'b0;
                    cnt_d   = 2'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                busy   = 1'b1;
                work_d = work_mixed;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 2'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            cnt_q   <= 2'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // The working register doubles as the output holding register.
    assign out_data = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_iter
//
// Four instances share clk/rst_n:
//   dut0: C=4, inverse enabled    dut1: C=2, inverse enabled
//   dut2: C=1, inverse enabled    dut3: C=4, forward only
// Stimulus pushes {instance, expected state, accept cycle} into a scoreboard
// queue; a monitor pops an entry whenever an instance raises out_valid and
// checks the instance, the data and the accept-to-valid latency.
// ---------------------------------------------------------------------------
module tb_mix_columns_iter;

    localparam int NDUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst_n     = 1'b1;
    logic [NDUT-1:0]             in_valid  = '0;
    logic [NDUT-1:0]             inv       = '0;
    logic [NDUT-1:0]             out_ready = '1;
    logic [NDUT-1:0][127:0]      in_data   = '0;
    logic [NDUT-1:0]             in_ready;
    logic [NDUT-1:0]             out_valid;
    logic [NDUT-1:0]             busy;
    logic [NDUT-1:0][127:0]      out_data;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int C  = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 1 : 4;
        localparam int EI = (g == 3) ? 0 : 1;
        mix_columns_iter #(
            .COLS_PER_CYCLE(C),
            .ENABLE_INV    (EI)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .inv      (inv[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .busy     (busy[g])
        );
    end

    // Known-answer vectors (forward direction: *_in -> *_out)
    localparam logic [127:0] WIKI_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] WIKI_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] D4_IN    = 128'hd4d4d4d52d26314c0000000001010101;
    localparam logic [127:0] D4_OUT   = 128'hd5d5d7d64d7ebdf80000000001010101;
    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] ONES     = 128'h01010101010101010101010101010101;

    typedef struct {
        int           id;
        logic [127:0] data;
        int           acc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [NDUT-1:0] prev_ov = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int g);
        case (g)
            1:       return 2;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model: schoolbook GF(2^8) multiply and matrix product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model_fwd(input logic [127:0] x);
        logic [15:0][7:0] xb, yb;
        logic [7:0]       coef [4];
        logic [7:0]       r;
        coef[0] = 8'h02;
        coef[1] = 8'h03;
        coef[2] = 8'h01;
        coef[3] = 8'h01;
        xb = x;
        yb = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    r = r ^ gmul(coef[2'((k - i + 4) % 4)], xb[4'(15 - 4 * c - k)]);
                end
                yb[4'(15 - 4 * c - i)] = r;
            end
        end
        return yb;
    endfunction

    // Monitor: one scoreboard entry per out_valid rising edge.
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (out_valid[g] && !prev_ov[g]) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output dut%0d: got %h, want no output", g, out_data[g]);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_int($sformatf("sb_id dut%0d", g), g, e.id);
                    check128($sformatf("sb_data dut%0d", g), out_data[g], e.data);
                    check_int($sformatf("sb_latency dut%0d", g), cyc - e.acc, lat(g));
                end
            end
        end
        prev_ov <= out_valid;
    end

    // Caller is positioned #1 after a rising edge.
    task automatic send(input int g, input logic [127:0] d, input logic m, input logic [127:0] expv);
        int t;
        t = 0;
        while (!in_ready[g] && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready[g]) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout dut%0d: in_ready=0, want 1", g);
            return;
        end
        in_data[g]  = d;
        inv[g]      = m;
        in_valid[g] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
        sb_q.push_back('{g, expv, cyc});
    endtask

    task automatic wait_done(input int g, input int exp_cycles);
        int n;
        n = 0;
        while (busy[g] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int($sformatf("cycles_to_idle dut%0d", g), n, exp_cycles);
    endtask

    initial begin
        logic [127:0] x, y;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        for (int g = 0; g < NDUT; g++) begin
            check_int($sformatf("rst_in_ready dut%0d", g), int'(in_ready[g]), 0);
            check_int($sformatf("rst_out_valid dut%0d", g), int'(out_valid[g]), 0);
            check_int($sformatf("rst_busy dut%0d", g), int'(busy[g]), 0);
            check128($sformatf("rst_out_data dut%0d", g), out_data[g], '0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check_int($sformatf("idle_in_ready dut%0d", g), int'(in_ready[g]), 1);
        end

        // C=4 forward
        send(0, WIKI_IN, 1'b0, WIKI_OUT);
        wait_done(0, 2);
        send(0, FIPS_IN, 1'b0, FIPS_OUT);
        wait_done(0, 2);

        // C=1 inverse, busy held through the transform
        send(2, WIKI_OUT, 1'b1, WIKI_IN);
        for (int k = 0; k < 4; k++) begin
            check_int($sformatf("c1_busy k%0d", k), int'(busy[2]), 1);
            check_int($sformatf("c1_no_valid k%0d", k), int'(out_valid[2]), 0);
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        wait_done(2, 2);

        // C=2 forward
        send(1, D4_IN, 1'b0, D4_OUT);
        wait_done(1, 3);
        send(1, FIPS_IN, 1'b0, FIPS_OUT);
        wait_done(1, 3);

        // Forward then inverse round trip on random states
        for (int g = 0; g < 3; g++) begin
            for (int r = 0; r < 3; r++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                y = model_fwd(x);
                send(g, x, 1'b0, y);
                wait_done(g, lat(g) + 1);
                send(g, y, 1'b1, x);
                wait_done(g, lat(g) + 1);
            end
        end

        // Backpressure on C=2 with an inverse transform
        out_ready[1] = 1'b0;
        send(1, WIKI_OUT, 1'b1, WIKI_IN);
        begin
            int t;
            t = 0;
            while (!out_valid[1] && t < 10) begin
                @(posedge clk);
                #1;
                t++;
            end
            check_int("bp_reach_done", int'(out_valid[1]), 1);
        end
        in_data[1]  = FIPS_IN;
        inv[1]      = 1'b0;
        in_valid[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check_int($sformatf("bp_out_valid k%0d", k), int'(out_valid[1]), 1);
            check128($sformatf("bp_out_data k%0d", k), out_data[1], WIKI_IN);
            check_int($sformatf("bp_in_ready k%0d", k), int'(in_ready[1]), 0);
        end
        // in_valid stays high across the DONE exit: not taken on that edge
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check_int("bp_exit_out_valid", int'(out_valid[1]), 0);
        check_int("bp_exit_in_ready", int'(in_ready[1]), 1);
        check_int("bp_exit_busy", int'(busy[1]), 0);
        check128("bp_exit_out_data_held", out_data[1], WIKI_IN);
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        sb_q.push_back('{1, FIPS_OUT, cyc});
        check_int("bp_next_accept_busy", int'(busy[1]), 1);
        wait_done(1, 3);

        // Forward-only instance ignores inv
        send(3, ONES, 1'b1, ONES);
        wait_done(3, 2);
        send(3, FIPS_IN, 1'b1, FIPS_OUT);
        wait_done(3, 2);
        send(3, WIKI_IN, 1'b1, WIKI_OUT);
        wait_done(3, 2);

        // Reset during the second BUSY cycle of the C=1 instance
        send(2, FIPS_IN, 1'b0, FIPS_OUT);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_int("midrst_out_valid", int'(out_valid[2]), 0);
        check128("midrst_out_data", out_data[2], '0);
        check_int("midrst_busy", int'(busy[2]), 0);
        check_int("midrst_in_ready", int'(in_ready[2]), 0);
        // The aborted state never produces output; drop its expectation.
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2, D4_IN, 1'b0, D4_OUT);
        wait_done(2, 5);

        repeat (3) @(posedge clk);
        #1;
        check_int("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want test completion");
        $fatal(1, "watchdog");
    end

endmodule
